dcache_dm: RTL and testbench
============================

Name: dcache_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits downstream of the instruction decoder. Consumes its RamRead/RamWrite strobes and the ALU-computed address; returns load data to the result mux.
- Stalls the core while main memory is accessed over a valid/ready request interface.
- Word accesses only; byte/half extraction and merging happen outside this block.

Parameters:
- W, 32, data and address width.
- IDX, 4, index bits; 2^IDX lines of one word each.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- RamRead  in  1  load strobe from decoder
- RamWrite  in  1  store strobe from decoder
- addr  in  W  byte address from ALU
- wdata  in  W  store data
- rdata  out  W  load data
- stall  out  1  freeze PC and pipeline while high
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  W  word-aligned memory address (bits [1:0] = 0)
- mem_wdata  out  W  memory write data
- mem_ready  in  1  memory completes request this cycle
- mem_rdata  in  W  memory read data, valid when mem_ready
- hit_cnt  out  CNT_W  completed load hits
- miss_cnt  out  CNT_W  completed load misses

Behaviour:
- Address split:
  - offset = addr[1:0], ignored.
  - index = addr[IDX+1:2].
  - tag = addr[W-1:IDX+2] (26 bits at defaults).
- Line storage: valid bit, tag, W-bit data per line.
- hit = valid[index] && tag_array[index] == tag. Combinational, evaluated in IDLE only.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - RamWrite=1 (has priority over RamRead):
    - Latch addr and wdata.
    - On a hit, update data[index] at this edge. On a miss, leave lines unchanged.
    - Go to WR_THRU. stall=1 this cycle.
  - RamRead=1, hit: rdata = data[index] combinationally; stall=0; hit_cnt+1 at the edge; stay in IDLE.
  - RamRead=1, miss: latch addr; go to RD_MISS; stall=1.
  - No strobe: stall=0, rdata=0.
- RD_MISS:
  - Outputs: mem_req=1, mem_we=0, mem_addr = latched address with [1:0]=0.
  - On mem_ready:
    - Fill line: valid=1, tag, data=mem_rdata. This evicts the previous occupant.
    - rdata = mem_rdata; stall=0 in the same cycle.
    - miss_cnt+1; go to IDLE.
- WR_THRU:
  - Outputs: mem_req=1, mem_we=1, mem_addr = aligned latched address, mem_wdata = latched wdata.
  - On mem_ready: stall=0; go to IDLE.
- stall = (state != IDLE && !mem_ready) || (state == IDLE && strobe && !(RamRead && hit && !RamWrite)).
- Latency:
  - Load hit: 0 stall cycles.
  - Load miss or any store: 1 + N stall cycles, where memory asserts mem_ready N cycles after mem_req rises. The access completes at the edge ending the mem_ready cycle.
- The core holds strobes, addr and wdata stable while stall=1. The block uses only latched values once it leaves IDLE.
- mem_req, once raised, stays high with stable addr/data until mem_ready (no withdrawal).
- Counters wrap modulo 2^CNT_W.
- Reset (rst=1 at an edge): all valid bits cleared, state=IDLE, counters=0.
  - While rst=1: mem_req=0, stall=0, rdata=0.
  - A memory transaction in flight is abandoned, and mem_ready arriving after reset is ignored.
  - Tag and data arrays need no reset.

Test Plan:
- Reset, then lw 0x100; memory returns 0xDEADBEEF with N=3 -> stall high 4 cycles; mem_addr=0x100 mem_we=0; rdata=0xDEADBEEF in the mem_ready cycle; miss_cnt=1.
- Immediately repeat lw 0x100 -> stall=0, rdata=0xDEADBEEF same cycle, no mem_req, hit_cnt=1.
- Conflict: lw 0x000 (miss), lw 0x040 (same index 0, miss, evicts), lw 0x000 -> third access misses again; miss_cnt=3, hit_cnt=0.
- sw 0x12345678 to cached 0x100 -> mem_req/mem_we=1, mem_wdata=0x12345678, stall until mem_ready; following lw 0x100 hits with 0x12345678.
- sw to uncached 0x200, then lw 0x200 -> store causes no allocation, so the load misses and fetches from memory; miss_cnt increments.
- rst asserted in cycle 2 of RD_MISS -> next cycle mem_req=0, stall=0, counters 0; lw to the previously filled line misses.

Source files
------------

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Stalls the core while a load miss or any store is serviced over a valid/ready memory port.
module dcache_dm #(
  parameter int W     = 32,
  parameter int IDX   = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RamRead,
  input  logic             RamWrite,
  input  logic [W-1:0]     addr,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [W-1:0]     mem_addr,
  output logic [W-1:0]     mem_wdata,
  input  logic             mem_ready,
  input  logic [W-1:0]     mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int LINES = 1 << IDX;
  localparam int TAG_W = W - IDX - 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } state_e;

  state_e             state_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [W-1:0]       data_q [LINES];
  logic [W-3:0]       addr_q;
  logic [W-1:0]       wdata_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic [CNT_W-1:0]   miss_cnt_q;

  logic [IDX-1:0]     idx;
  logic [TAG_W-1:0]   tag;
  logic [IDX-1:0]     idx_q;
  logic               hit;
  logic               in_idle;
  logic               ld_hit;
  logic               wr_hit;
  logic               fill;

  assign idx     = addr[IDX+1:2];
  assign tag     = addr[W-1:IDX+2];
  assign idx_q   = addr_q[IDX-1:0];
  assign hit     = valid_q[idx] && (tag_q[idx] == tag);
  assign in_idle = (state_q == IDLE);
  assign ld_hit  = in_idle && RamRead && !RamWrite && hit;
  assign wr_hit  = !rst && in_idle && RamWrite && hit;
  assign fill    = !rst && (state_q == RD_MISS) && mem_ready;

  // Control state: FSM, valid bits and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (RamWrite) begin
            state_q <= WR_THRU;
          end else if (RamRead) begin
            if (hit) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            else     state_q   <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (mem_ready) begin
            valid_q[idx_q] <= 1'b1;
            miss_cnt_q     <= miss_cnt_q + CNT_W'(1);
            state_q        <= IDLE;
          end
        end
        WR_THRU: begin
          if (mem_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays and latched request fields carry no reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (in_idle && (RamRead || RamWrite)) addr_q  <= addr[W-1:2];
    if (in_idle && RamWrite)              wdata_q <= wdata;
    if (wr_hit) data_q[idx] <= wdata;
    if (fill) begin
      tag_q[idx_q]  <= addr_q[W-3:IDX];
      data_q[idx_q] <= mem_rdata;
    end
  end

  assign mem_req   = !rst && !in_idle;
  assign mem_we    = (state_q == WR_THRU);
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rdata = '0;
    stall = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          stall = (RamRead || RamWrite) && !ld_hit;
          if (ld_hit) rdata = data_q[idx];
        end
        RD_MISS: begin
          stall = !mem_ready;
          if (mem_ready) rdata = mem_rdata;
        end
        WR_THRU: stall = !mem_ready;
        default: stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// Randomized scoreboard bench for dcache_dm: a word-level memory/cache reference model
// predicts load data, stall length and memory traffic; a monitor compares what the DUT presents.
module tb_dcache_dm;

  localparam int LINES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RamRead, RamWrite;
  logic [31:0] addr, wdata, rdata;
  logic        stall, mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_cnt, miss_cnt;

  dcache_dm #(.W(32), .IDX(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .RamRead(RamRead), .RamWrite(RamWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] rdata;
    int          stalls;
  } acc_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  acc_t  exp_acc[$];
  mreq_t exp_mem[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Memory as seen by the responder (written only by DUT stores) and by the reference model.
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];

  // Reference cache: which word-address block each line holds, by plain arithmetic.
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  int unsigned m_hits   = 0;
  int unsigned m_misses = 0;

  int          lat_next  = 2;
  int          stray_cnt = 0;
  logic [31:0] stray_data = 32'h0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : mem_init(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  task automatic summary_and_finish();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // Memory responder: raises mem_ready lat_next cycles after mem_req rises.
  initial begin : mem_proc
    bit busy;
    int cnt;
    int lat;
    int stray_seen;
    busy = 0; cnt = 0; lat = 0; stray_seen = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        mem_ready  = 1'b1;
        mem_rdata  = stray_data;
        busy       = 0;
      end else if (rst || !mem_req) begin
        busy = 0;
      end else begin
        if (!busy) begin
          busy = 1; cnt = 0; lat = lat_next;
        end else begin
          cnt++;
        end
        if (cnt == lat) begin
          mem_ready = 1'b1;
          busy      = 0;
          if (mem_we) phys_mem[mem_addr] = mem_wdata;
          else        mem_rdata = phys_rd(mem_addr);
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT completes an access or a memory transfer.
  initial begin : monitor
    int    cur_stall;
    acc_t  a;
    mreq_t m;
    cur_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_acc.delete();
        exp_mem.delete();
        cur_stall = 0;
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
      end else begin
        if (mem_req && mem_ready) begin
          if (exp_mem.size() == 0) begin
            check("mem_unexpected", 32'h1, 32'h0);
          end else begin
            m = exp_mem.pop_front();
            check("mem_we", {31'b0, mem_we}, {31'b0, m.we});
            check("mem_addr", mem_addr, m.addr);
            if (m.we) check("mem_wdata", mem_wdata, m.wdata);
          end
        end
        if (RamRead || RamWrite) begin
          if (stall) begin
            cur_stall++;
          end else begin
            if (exp_acc.size() == 0) begin
              check("acc_unexpected", 32'h1, 32'h0);
            end else begin
              a = exp_acc.pop_front();
              check("stall_cycles", cur_stall, a.stalls);
              if (!a.is_wr) check("load_rdata", rdata, a.rdata);
            end
            cur_stall = 0;
          end
        end else begin
          check("idle_stall", {31'b0, stall}, 32'h0);
          check("idle_rdata", rdata, 32'h0);
        end
      end
    end
  end

  // Issues one access at posedge+1 and returns at the posedge+1 after it completes.
  task automatic access(input bit wr, input bit both, input logic [31:0] a,
                        input logic [31:0] d, input int lat);
    logic [31:0] wa  = {a[31:2], 2'b00};
    int          idx = int'((a >> 2) % LINES);
    logic [31:0] tg  = a >> 6;
    bit          hit = m_valid[idx] && (m_tag[idx] == tg);
    acc_t        e;
    mreq_t       m;
    bit          done = 0;
    lat_next = lat;
    if (wr) begin
      ref_mem[wa] = d;
      e = '{1'b1, 32'h0, 1 + lat};
      m = '{1'b1, wa, d};
      exp_mem.push_back(m);
    end else if (hit) begin
      e = '{1'b0, ref_rd(wa), 0};
      m_hits++;
    end else begin
      e = '{1'b0, ref_rd(wa), 1 + lat};
      m = '{1'b0, wa, 32'h0};
      exp_mem.push_back(m);
      m_valid[idx] = 1;
      m_tag[idx]   = tg;
      m_misses++;
    end
    exp_acc.push_back(e);
    RamWrite = wr;
    RamRead  = !wr || both;
    addr     = a;
    wdata    = d;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      check("access_timeout", 32'h1, 32'h0);
      summary_and_finish();
    end
    @(posedge clk); #1;
    RamRead  = 1'b0;
    RamWrite = 1'b0;
  endtask

  task automatic check_cnt();
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
  endtask

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] a;
    int          r;
    rst = 1'b1; RamRead = 1'b0; RamWrite = 1'b0; addr = 32'h0; wdata = 32'h0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_cnt();

    // First miss with N=3, then an immediate hit.
    phys_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100]  = 32'hDEAD_BEEF;
    access(0, 0, 32'h100, 32'h0, 3);
    check_cnt();
    access(0, 0, 32'h100, 32'h1111_2222, 3);
    check_cnt();

    // Conflict on index 0: third access misses again.
    access(0, 0, 32'h000, 32'h0, 1);
    access(0, 0, 32'h040, 32'h0, 1);
    access(0, 0, 32'h002, 32'h0, 1);
    check_cnt();

    // Store hit updates the line; store miss does not allocate.
    access(1, 0, 32'h100, 32'h1234_5678, 2);
    access(0, 0, 32'h101, 32'h0, 2);
    access(1, 1, 32'h200, 32'hCAFE_F00D, 1);
    access(0, 0, 32'h200, 32'h0, 0);
    check_cnt();

    // Random traffic over a small tag range so hits, evictions and store hits all occur.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 85) a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      else        a = $urandom;
      access($urandom_range(0, 99) < 30, $urandom_range(0, 1) == 1, a, $urandom,
             int'($urandom_range(0, 4)));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    check_cnt();

    // Reset in the second RD_MISS cycle; a late mem_ready must be ignored.
    access(0, 0, 32'h100, 32'h0, 1);
    lat_next = 5;
    RamRead  = 1'b1;
    addr     = 32'h3C0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst     = 1'b1;
    RamRead = 1'b0;
    @(posedge clk); #1;
    rst        = 1'b0;
    stray_data = 32'hBAD0_BAD0;
    stray_cnt++;
    clear_model();
    check_cnt();
    check("post_rst_mem_req", {31'b0, mem_req}, 32'h0);
    @(posedge clk); #1;
    check_cnt();
    access(0, 0, 32'h100, 32'h0, 2);
    check_cnt();

    repeat (2) @(posedge clk);
    #1;
    summary_and_finish();
  end

endmodule
